// File: rtl/probe_pkg.sv
// Shared definitions for the probe buffer family: word width, control states
// and the fill words returned when a read finds nothing to pop.
package probe_pkg;

  localparam int PROBE_W = 64;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEALED = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [PROBE_W-1:0] FILL_BASE_C = {PROBE_W{1'b1}};
  localparam logic [PROBE_W-1:0] FILL_VAR_C  = {PROBE_W{1'b0}};

  // Base and variant copies answer misses with different words so divergence is visible.
  function automatic logic [PROBE_W-1:0] fill_value(input logic is_variant);
    return is_variant ? FILL_VAR_C : FILL_BASE_C;
  endfunction

endpackage

// File: rtl/probe_replay_buffer_if.sv
// Harness push handshake and DUT-side read port of the replay buffer.
// The master modport is the harness/DUT side; the buffer takes the slave modport.
interface probe_replay_buffer_if
  import probe_pkg::*;
#(
  parameter int DATA_W = PROBE_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              ren;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rhit;

  modport master (
    output in_valid, in_data, in_last, ren,
    input  in_ready, rvalid, rdata, rhit
  );

  modport slave (
    input  in_valid, in_data, in_last, ren,
    output in_ready, rvalid, rdata, rhit
  );
endinterface

// File: rtl/probe_fifo_mem.sv
// DEPTH x DATA_W word store with one write port and one registered read port.
// Pointers wrap naturally because DEPTH is a power of two.
module probe_fifo_mem
  import probe_pkg::*;
#(
  parameter int DATA_W = PROBE_W,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [DATA_W-1:0] rdata_r;

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (we) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (re) rd_ptr_r <= rd_ptr_r + AW'(1'b1);
    end
  end

  // Storage and read register carry no reset; the top only trusts rdata after a hit.
  always_ff @(posedge clock) begin
    if (we) mem_r[wr_ptr_r] <= wdata;
    if (re) rdata_r <= mem_r[rd_ptr_r];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/probe_replay_buffer.sv
// Host-to-DUT replay FIFO: the harness pushes stimulus words, DUT logic pops them
// with a one-cycle read; empty or finished reads return a per-copy fill word.
module probe_replay_buffer
  import probe_pkg::*;
#(
  parameter int                DATA_W     = PROBE_W,
  parameter int                DEPTH      = 16,
  parameter bit                IS_VARIANT = 1'b0,
  parameter logic [DATA_W-1:0] FILL_BASE  = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] FILL_VAR   = {DATA_W{1'b0}}
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  probe_replay_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              miss_count,
  output logic                     done
);

  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [DATA_W-1:0] FILL_VAL = IS_VARIANT ? FILL_VAR : FILL_BASE;

  state_e            state_r;
  state_e            state_s;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_s;
  logic [31:0]       miss_r;
  logic              rvalid_r;
  logic              rhit_r;
  logic              done_r;
  logic              clear_s;
  logic              in_ready_s;
  logic              push_s;
  logic              pop_s;
  logic              miss_s;
  logic [DATA_W-1:0] mem_rdata_s;

  assign clear_s    = ~reset | flush;
  assign in_ready_s = (state_r == FILL) && (count_r != DEPTH_C);

  // Handshake decode, occupancy update and next state.
  always_comb begin
    push_s  = bus.in_valid & in_ready_s;
    pop_s   = bus.ren & (count_r != {CW{1'b0}}) & (state_r != DONE);
    miss_s  = bus.ren & ~pop_s;
    count_s = count_r + CW'(push_s) - CW'(pop_s);
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (push_s && bus.in_last) begin
          state_s = (count_s == {CW{1'b0}}) ? DONE : SEALED;
        end else begin
          state_s = FILL;
        end
      end
      SEALED: begin
        if (count_s == {CW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = SEALED;
        end
      end
      DONE:    state_s = DONE;
      default: state_s = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear_s) state_r <= FILL;
    else         state_r <= state_s;
  end

  // Counters and the read response; rhit only moves when a read is issued.
  always_ff @(posedge clock) begin
    if (clear_s) begin
      count_r  <= {CW{1'b0}};
      miss_r   <= 32'd0;
      rvalid_r <= 1'b0;
      rhit_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      count_r  <= count_s;
      rvalid_r <= bus.ren;
      done_r   <= (state_s == DONE);
      if (bus.ren) rhit_r <= pop_s;
      if (miss_s && (miss_r != 32'hFFFF_FFFF)) miss_r <= miss_r + 32'd1;
    end
  end

  probe_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .clear (clear_s),
    .we    (push_s & ~clear_s),
    .wdata (bus.in_data),
    .re    (pop_s & ~clear_s),
    .rdata (mem_rdata_s)
  );

  assign bus.in_ready = in_ready_s;
  assign bus.rvalid   = rvalid_r;
  assign bus.rhit     = rhit_r;
  assign bus.rdata    = rhit_r ? mem_rdata_s : FILL_VAL;
  assign count        = count_r;
  assign miss_count   = miss_r;
  assign done         = done_r;

endmodule
